midi_rx_parser: RTL
===================

Name: midi_rx_parser

Overview:
Upstream front end for the slot-4 MIDI core. It receives the raw MIDI serial line (31250 baud, 8N1) from the board pin and deserialises bytes. It then assembles complete channel-voice messages, including running status. Each message goes to the MIDI core over a valid/ready handshake, so the core's register interface only handles whole messages.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 31250, MIDI bit rate
OVS, 16, oversampling ticks per bit; tick divisor DVSR = CLK_FREQ/(BAUD*OVS) = 200 at defaults

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset=0 resets all state on the next clk edge)
midi_in  in  1  asynchronous MIDI serial line, idle high
msg_valid  out  1  complete message held on msg_* outputs
msg_ready  in  1  consumer accepts message when msg_valid & msg_ready at a clk edge
msg_status  out  8  status byte (running status re-inserted)
msg_data1  out  7  first data byte (0 if message has none)
msg_data2  out  7  second data byte (0 if message has one or none)
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: message completed while msg_valid=1 and not accepted

Behaviour:
- Reset values: msg_valid=0, msg_status=0, msg_data1=0, msg_data2=0, frame_err=0, overrun=0. Running status is cleared. Both FSMs go to their idle state. The tick counter is 0.
- midi_in: 2-FF synchroniser. The synchroniser resets to 1 (idle).
- Tick generator: free-running counter 0..DVSR-1 that pulses s_tick when it wraps.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: wait for synced line = 0, then clear the tick count and go to START.
  - START: at tick 7 re-check the line. If 0, go to DATA. If 1, it was a glitch; return to IDLE.
  - DATA: sample every 16 ticks, 8 bits, LSB first.
  - STOP: at tick 15 sample the stop bit. If 1, pulse rx_done with the byte. If 0, pulse frame_err and discard the byte. Either way return to IDLE.
- Parser FSM, states WAIT_STATUS, WAIT_D1, WAIT_D2. Data length by status: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn take 2 bytes; 0xCn, 0xDn take 1.
  - Byte 0x80..0xEF: latch as running status and go to WAIT_D1, from any state. A partially received message is abandoned.
  - Byte 0xF0..0xF7: clear running status, go to WAIT_STATUS, no output.
  - Byte 0xF8..0xFF (real-time): no state change and running status kept; handling depends on the optional feature.
  - Data byte (bit7=0) in WAIT_STATUS with running status valid: treat as D1 of the running-status message.
  - Data byte in WAIT_STATUS without running status: dropped.
  - WAIT_D1: latch D1. For 1-byte messages emit and return to WAIT_STATUS; otherwise go to WAIT_D2.
  - WAIT_D2: latch D2, emit, return to WAIT_STATUS.
- Emit: on the cycle after rx_done of the final byte, msg_valid=1 and msg_* are loaded.
  - Outputs stay stable until the handshake; msg_valid drops the cycle after acceptance.
  - If msg_valid=1 and a new message completes in the same cycle as acceptance, the new message loads and msg_valid stays 1.
  - If msg_valid=1 and it is not accepted, the new message is dropped and overrun pulses.
- Reset mid-byte or mid-message: all state and outputs return to their reset values; the partial message is lost.

Optional Feature:
MIDI_REALTIME_EN
- Defined: bytes 0xF8..0xFF are emitted immediately as single-byte messages (status=byte, data1=data2=0). They use the same overrun rule and do not disturb the parser state or partial-message registers.
- Undefined: real-time bytes are silently discarded.

Decomposition:
- Package midi_pkg holds:
  - parser state enum and RX state enum;
  - constants ST_NOTE_OFF=0x80 .. ST_PITCH=0xE0, SYS_COMMON_MIN=0xF0, REALTIME_MIN=0xF8;
  - function data_len(status) returning 0, 1 or 2.
- One sub-module: midi_uart_rx (synchroniser, tick generator, RX FSM; outputs rx_done, rx_byte, frame_err).
- The parser and output register live in midi_rx_parser.

Test Plan (defaults; bit period 3200 cycles):
- Send 0x90,0x3C,0x64 with msg_ready=1 -> one msg_valid pulse, status=0x90, d1=0x3C, d2=0x64, valid 1 cycle after the last stop-bit sample.
- Send 0x90,0x3C,0x64 then 0x40,0x00 -> second message status=0x90, d1=0x40, d2=0x00 (running status).
- Send 0xC5,0x0A -> status=0xC5, d1=0x0A, d2=0.
- Send 0x80,0x3C, then 0xF8, then 0x7F:
  - undefined -> one message 0x80/0x3C/0x7F;
  - with MIDI_REALTIME_EN -> 0xF8 message first, then the note-off.
- Force the stop bit low on byte 0x90, then send 0x3C,0x64 -> frame_err pulses once; no message is emitted (no running status).
- Hold msg_ready=0 and send two 1-byte messages 0xD0,0x10 and 0xD0,0x20 -> first held stable, overrun pulses once, second dropped; reset=0 mid-byte clears msg_valid.

Source files
------------

// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared types and constants for the MIDI receive front end.
//   rx_state_t     : byte-deserialiser states
//   parse_state_t  : message-assembly states
//   ST_* / *_MIN   : status byte constants
//   data_len()     : number of data bytes that follow a status byte
// ---------------------------------------------------------------------------
package midi_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_D1,
    P_WAIT_D2
  } parse_state_t;

  localparam logic [7:0] ST_NOTE_OFF    = 8'h80;
  localparam logic [7:0] ST_NOTE_ON     = 8'h90;
  localparam logic [7:0] ST_POLY_AT     = 8'hA0;
  localparam logic [7:0] ST_CTRL        = 8'hB0;
  localparam logic [7:0] ST_PROG        = 8'hC0;
  localparam logic [7:0] ST_CHAN_AT     = 8'hD0;
  localparam logic [7:0] ST_PITCH       = 8'hE0;
  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  // Channel number is ignored; only the upper nibble selects the length.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case ({status[7:4], 4'h0})
      ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: len = 2'd2;
      ST_PROG, ST_CHAN_AT:                                     len = 2'd1;
      default:                                                 len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// ---------------------------------------------------------------------------
// midi_uart_rx
// 8N1 serial byte receiver with oversampling.
//   clk          system clock
//   reset        synchronous, active-low
//   i_rx         asynchronous serial line, idle high
//   o_rx_done    one-cycle pulse: valid byte on o_rx_byte
//   o_rx_byte    received byte (LSB first on the line)
//   o_frame_err  one-cycle pulse: stop bit sampled low, byte discarded
// ---------------------------------------------------------------------------
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 31250,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_rx_done,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err
);

  localparam int DVSR = CLK_FREQ / (BAUD * OVS);
  localparam int TW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW   = $clog2(OVS);
  localparam logic [TW-1:0] T_LAST = TW'(DVSR - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

  // Two-flop synchroniser; idle-high reset so no false start bit after reset.
  logic r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running oversample tick.
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == T_LAST);

  always_ff @(posedge clk) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  rx_state_t     r_state, w_state_nx;
  logic [SW-1:0] r_s, w_s_nx;
  logic [2:0]    r_n, w_n_nx;
  logic [7:0]    r_b, w_b_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RX_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
    end
  end

  // Start bit is confirmed at mid-bit (OVS/2 ticks); every later sample is
  // then a full bit period apart, so data and stop land on bit centres.
  always_comb begin
    w_state_nx  = r_state;
    w_s_nx      = r_s;
    w_n_nx      = r_n;
    w_b_nx      = r_b;
    o_rx_done   = 1'b0;
    o_frame_err = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!r_sync2) begin
          w_s_nx     = '0;
          w_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_s == S_MID) begin
            if (!r_sync2) begin
              w_s_nx     = '0;
              w_n_nx     = '0;
              w_state_nx = RX_DATA;
            end else begin
              w_state_nx = RX_IDLE;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx = '0;
            w_b_nx = {r_sync2, r_b[7:1]};
            if (r_n == 3'd7) w_state_nx = RX_STOP;
            else             w_n_nx     = r_n + 1'b1;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            if (r_sync2) o_rx_done   = 1'b1;
            else         o_frame_err = 1'b1;
            w_state_nx = RX_IDLE;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

  assign o_rx_byte = r_b;

endmodule

// File: rtl/midi_rx_parser.sv
// ---------------------------------------------------------------------------
// midi_rx_parser
// MIDI serial receiver and channel-voice message assembler with running
// status. Whole messages are presented on a valid/ready handshake.
//   clk         system clock
//   reset       synchronous, active-low
//   midi_in     asynchronous MIDI line, idle high
//   msg_valid   message held on msg_* outputs
//   msg_ready   consumer accept
//   msg_status  status byte (running status re-inserted)
//   msg_data1   first data byte, 0 if none
//   msg_data2   second data byte, 0 if none
//   frame_err   one-cycle pulse on a bad stop bit
//   overrun     one-cycle pulse when a message is lost to a held output
// Build option: define MIDI_REALTIME_EN to forward real-time bytes
// (0xF8..0xFF) as single-byte messages; otherwise they are discarded.
// ---------------------------------------------------------------------------
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 31250,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_in,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       frame_err,
  output logic       overrun
);

  logic       w_rx_done;
  logic [7:0] w_rx_byte;
  logic       w_frame_err;

  midi_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) u_uart_rx (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (midi_in),
    .o_rx_done   (w_rx_done),
    .o_rx_byte   (w_rx_byte),
    .o_frame_err (w_frame_err)
  );

  // Running status uses bit 7 as its valid flag (cleared value 0x00).
  parse_state_t r_pstate, w_pstate_nx;
  logic [7:0]   r_run_status, w_run_nx;
  logic [6:0]   r_d1, w_d1_nx;

  logic       w_emit;
  logic [7:0] w_emit_status;
  logic [6:0] w_emit_d1;
  logic [6:0] w_emit_d2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pstate     <= P_WAIT_STATUS;
      r_run_status <= '0;
      r_d1         <= '0;
    end else begin
      r_pstate     <= w_pstate_nx;
      r_run_status <= w_run_nx;
      r_d1         <= w_d1_nx;
    end
  end

  always_comb begin
    w_pstate_nx   = r_pstate;
    w_run_nx      = r_run_status;
    w_d1_nx       = r_d1;
    w_emit        = 1'b0;
    w_emit_status = '0;
    w_emit_d1     = '0;
    w_emit_d2     = '0;
    if (w_rx_done) begin
      if (w_rx_byte >= REALTIME_MIN) begin
        // Real-time bytes may interleave anywhere; parser state is untouched.
`ifdef MIDI_REALTIME_EN
        w_emit        = 1'b1;
        w_emit_status = w_rx_byte;
`endif
      end else if (w_rx_byte >= SYS_COMMON_MIN) begin
        w_run_nx    = '0;
        w_pstate_nx = P_WAIT_STATUS;
      end else if (w_rx_byte[7]) begin
        w_run_nx    = w_rx_byte;
        w_pstate_nx = P_WAIT_D1;
      end else begin
        unique case (r_pstate)
          P_WAIT_STATUS, P_WAIT_D1: begin
            // WAIT_STATUS with a live running status behaves as WAIT_D1.
            if (r_run_status[7]) begin
              if (data_len(r_run_status) == 2'd1) begin
                w_emit        = 1'b1;
                w_emit_status = r_run_status;
                w_emit_d1     = w_rx_byte[6:0];
                w_pstate_nx   = P_WAIT_STATUS;
              end else begin
                w_d1_nx     = w_rx_byte[6:0];
                w_pstate_nx = P_WAIT_D2;
              end
            end
          end
          P_WAIT_D2: begin
            w_emit        = 1'b1;
            w_emit_status = r_run_status;
            w_emit_d1     = r_d1;
            w_emit_d2     = w_rx_byte[6:0];
            w_pstate_nx   = P_WAIT_STATUS;
          end
          default: w_pstate_nx = P_WAIT_STATUS;
        endcase
      end
    end
  end

  // Output holding register. A new message may replace the held one only in
  // the cycle it is being accepted; otherwise the new one is dropped.
  logic       r_msg_valid;
  logic [7:0] r_msg_status;
  logic [6:0] r_msg_d1;
  logic [6:0] r_msg_d2;
  logic       r_frame_err;
  logic       r_overrun;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_msg_valid  <= 1'b0;
      r_msg_status <= '0;
      r_msg_d1     <= '0;
      r_msg_d2     <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_emit) begin
        if (!r_msg_valid || msg_ready) begin
          r_msg_valid  <= 1'b1;
          r_msg_status <= w_emit_status;
          r_msg_d1     <= w_emit_d1;
          r_msg_d2     <= w_emit_d2;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_msg_valid && msg_ready) begin
        r_msg_valid <= 1'b0;
      end
    end
  end

  assign msg_valid  = r_msg_valid;
  assign msg_status = r_msg_status;
  assign msg_data1  = r_msg_d1;
  assign msg_data2  = r_msg_d2;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
